// File: rtl/bp_pht_ctrl_if.sv
// Fetch/commit-side bundle of the gshare predictor controller: lookup request
// and prediction, training-update handshake, and init status.
interface bp_pht_ctrl_if #(
    parameter int GHR_W = 6
);
    logic             lookup_valid;
    logic [31:0]      lookup_pc;
    logic             pred_taken;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic             upd_ready;
    logic [31:0]      upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispredict;
    logic             init_busy;

    // Fetch/commit side.
    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  pred_taken, pred_ghr, upd_ready, init_busy
    );

    // Predictor side.
    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output pred_taken, pred_ghr, upd_ready, init_busy
    );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Gshare branch-direction predictor controller. Owns a PHT of 2-bit saturating
// counters and the speculative GHR, answers one lookup per cycle with zero
// latency, queues commit-time training updates and drains them one per cycle.
// After reset the PHT is swept to weak-taken before normal operation starts.
module bp_pht_ctrl #(
    parameter int PHT_IDX_W   = 6,
    parameter int GHR_W       = 6,
    parameter int UPD_Q_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    bp_pht_ctrl_if.slave  bus
);
    localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
    localparam int QPTR_W      = $clog2(UPD_Q_DEPTH);
    localparam int QCNT_W      = QPTR_W + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    logic [PHT_IDX_W-1:0] init_cnt;
    logic                 init_busy_q;
    logic [GHR_W-1:0]     ghr;

    // NOTE: the PHT and queue payload are plain storage without reset; the
    // init sweep defines every PHT entry and the queue pointers guard the rest.
    logic [1:0]           pht     [PHT_ENTRIES];
    logic [PHT_IDX_W-1:0] q_idx   [UPD_Q_DEPTH];
    logic                 q_taken [UPD_Q_DEPTH];
    logic [QPTR_W-1:0]    q_head;
    logic [QPTR_W-1:0]    q_tail;
    logic [QCNT_W-1:0]    q_count;

    logic                 run;
    logic                 upd_accept;
    logic                 drain;
    logic [PHT_IDX_W-1:0] lookup_idx;
    logic [PHT_IDX_W-1:0] upd_idx;
    logic [1:0]           lookup_ctr;
    logic [PHT_IDX_W-1:0] head_idx;
    logic [1:0]           head_ctr;
    logic [1:0]           head_next;

    // Gshare index: PC word-index bits XOR the zero-extended history.
    function automatic logic [PHT_IDX_W-1:0] pht_idx(
        input logic [PHT_IDX_W-1:0] pc_bits,
        input logic [GHR_W-1:0]     h
    );
        logic [PHT_IDX_W-1:0] hx;
        hx           = '0;
        hx[GHR_W-1:0] = h;
        return pc_bits ^ hx;
    endfunction

    // Lookup, handshake and drain read-modify-write datapath.
    always_comb begin
        // NOTE: every output of this block gets a value up front so no path
        // leaves one unassigned and no latch is inferred.
        head_next      = '0;
        run            = (state == ST_RUN) && !rst;
        lookup_idx     = pht_idx(bus.lookup_pc[PHT_IDX_W+1:2], ghr);
        upd_idx        = pht_idx(bus.upd_pc[PHT_IDX_W+1:2], bus.upd_ghr);
        lookup_ctr     = pht[lookup_idx];
        bus.pred_taken = run && lookup_ctr[1];
        bus.pred_ghr   = ghr;
        bus.upd_ready  = run && (q_count != QCNT_W'(UPD_Q_DEPTH));
        bus.init_busy  = init_busy_q;
        upd_accept     = bus.upd_valid && bus.upd_ready;
        drain          = run && (q_count != '0);
        head_idx       = q_idx[q_head];
        head_ctr       = pht[head_idx];
        if (q_taken[q_head]) begin
            head_next = (head_ctr == 2'b11) ? 2'b11 : head_ctr + 2'b01;
        end else begin
            head_next = (head_ctr == 2'b00) ? 2'b00 : head_ctr - 2'b01;
        end
    end

    // Init/run sequencer: sweeps init_cnt across the PHT, then enters RUN.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            init_busy_q <= 1'b1;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + PHT_IDX_W'(1);
            if (init_cnt == '1) begin
                state       <= ST_RUN;
                init_busy_q <= 1'b0;
            end
        end
    end

    // Single PHT write port: init sweep or drain of the queue head.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            pht[init_cnt] <= 2'b10;
        end else if (drain) begin
            pht[head_idx] <= head_next;
        end
    end

    // Queue payload write on accepted updates.
    always_ff @(posedge clk) begin
        if (upd_accept) begin
            q_idx[q_tail]   <= upd_idx;
            q_taken[q_tail] <= bus.upd_taken;
        end
    end

    // Queue pointers and occupancy; pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (upd_accept) q_tail <= q_tail + QPTR_W'(1);
            if (drain)      q_head <= q_head + QPTR_W'(1);
            if (upd_accept && !drain) begin
                q_count <= q_count + QCNT_W'(1);
            end else if (drain && !upd_accept) begin
                q_count <= q_count - QCNT_W'(1);
            end
        end
    end

    // Speculative history: mispredict restore wins over the lookup shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (run) begin
            if (upd_accept && bus.upd_mispredict) begin
                ghr <= {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
            end else if (bus.lookup_valid) begin
                ghr <= {ghr[GHR_W-2:0], bus.pred_taken};
            end
        end
    end

    // An underflow wraps the counter above the depth, so one bound covers both.
    assert property (@(posedge clk) disable iff (rst) q_count <= QCNT_W'(UPD_Q_DEPTH))
        else $error("bp_pht_ctrl: update queue count out of range");

    // Address bits outside the index field and the dropped history MSB.
    logic unused_bits;
    assign unused_bits = ^{bus.lookup_pc[31:PHT_IDX_W+2], bus.lookup_pc[1:0],
                           bus.upd_pc[31:PHT_IDX_W+2], bus.upd_pc[1:0],
                           bus.upd_ghr[GHR_W-1], lookup_ctr[0]};
endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Self-checking bench for bp_pht_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the predictor.
module tb_bp_pht_ctrl;
    localparam int IDX_W    = 6;
    localparam int GHR_W    = 6;
    localparam int QD       = 4;
    localparam int N        = 1 << IDX_W;
    localparam int GHR_MASK = (1 << GHR_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_pht_ctrl_if #(.GHR_W(GHR_W)) bus ();

    bp_pht_ctrl #(.PHT_IDX_W(IDX_W), .GHR_W(GHR_W), .UPD_Q_DEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: counters as integers, history as an integer,
    // pending training updates as a FIFO queue.
    typedef struct { int idx; int taken; } upd_t;
    int   m_pht [N];
    int   m_ghr       = 0;
    int   m_init_left = N;
    upd_t m_q [$];

    function automatic int m_idx(input logic [31:0] pc, input int h);
        return int'(((pc >> 2) ^ 32'(h)) & 32'(N - 1));
    endfunction

    function automatic bit exp_pred(input logic [31:0] pc);
        if (m_init_left > 0) return 1'b0;
        return m_pht[m_idx(pc, m_ghr)] >= 2;
    endfunction

    function automatic bit exp_ready();
        return (m_init_left == 0) && (m_q.size() < QD);
    endfunction

    function automatic logic [31:0] pc_for_idx(input int i);
        logic [31:0] r;
        r = $urandom & ~32'h0000_00FC;
        return r | (32'((i ^ m_ghr) & (N - 1)) << 2);
    endfunction

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic cycle();
        bit   pred;
        bit   acc;
        upd_t e;
        if (rst) begin
            m_init_left = N;
            m_ghr       = 0;
            m_q.delete();
        end else if (m_init_left > 0) begin
            m_pht[N - m_init_left] = 2;
            m_init_left--;
        end else begin
            pred = exp_pred(bus.lookup_pc);
            acc  = bus.upd_valid && (m_q.size() < QD);
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                if (e.taken != 0) m_pht[e.idx] = (m_pht[e.idx] == 3) ? 3 : m_pht[e.idx] + 1;
                else              m_pht[e.idx] = (m_pht[e.idx] == 0) ? 0 : m_pht[e.idx] - 1;
            end
            if (acc) m_q.push_back('{m_idx(bus.upd_pc, int'(bus.upd_ghr)), int'(bus.upd_taken)});
            if (acc && bus.upd_mispredict) m_ghr = ((int'(bus.upd_ghr) << 1) | int'(bus.upd_taken)) & GHR_MASK;
            else if (bus.lookup_valid)     m_ghr = ((m_ghr << 1) | int'(pred)) & GHR_MASK;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        repeat (n) cycle();
    endtask

    // Present one training update and hold it until accepted (bounded).
    task automatic send_upd(input logic [31:0] pc, input logic [GHR_W-1:0] h,
                            input logic tk, input logic mp);
        int waited = 0;
        bus.upd_pc = pc; bus.upd_ghr = h; bus.upd_taken = tk; bus.upd_mispredict = mp;
        bus.upd_valid = 1'b1;
        #1;
        while (!exp_ready() && waited < 20) begin
            cycle();
            waited++;
        end
        n_vec++;
        if (bus.upd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_upd_ready: upd_ready=%b required 1 after %0d cycles", bus.upd_ready, waited);
        end
        cycle();
        bus.upd_valid = 1'b0;
    endtask

    // Watch one full init sweep: busy length and blocked handshake.
    task automatic watch_init(input string tag);
        int busy_cnt = 0;
        for (int i = 0; i < N + 6; i++) begin
            if (m_init_left > 0) begin
                bus.lookup_valid = 1'($urandom);
                bus.lookup_pc    = $urandom;
                bus.upd_valid    = 1'($urandom);
                bus.upd_pc       = $urandom;
                bus.upd_ghr      = GHR_W'($urandom);
                bus.upd_mispredict = 1'($urandom);
            end else begin
                bus.lookup_valid = 1'b0;
                bus.upd_valid    = 1'b0;
            end
            #1;
            n_vec++;
            if (bus.init_busy !== (m_init_left > 0)) begin
                n_err++;
                $display("FAIL %s_busy cyc%0d: init_busy=%b required %b", tag, i, bus.init_busy, m_init_left > 0);
            end
            n_vec++;
            if (bus.upd_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL %s_ready cyc%0d: upd_ready=%b required %b", tag, i, bus.upd_ready, exp_ready());
            end
            n_vec++;
            if (bus.pred_ghr !== GHR_W'(m_ghr)) begin
                n_err++;
                $display("FAIL %s_ghr cyc%0d: pred_ghr=%b required %b", tag, i, bus.pred_ghr, GHR_W'(m_ghr));
            end
            if (m_init_left > 0 && bus.lookup_valid) begin
                n_vec++;
                if (bus.pred_taken !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_pred cyc%0d: pred_taken=%b required 0", tag, i, bus.pred_taken);
                end
            end
            if (bus.init_busy === 1'b1) busy_cnt++;
            cycle();
        end
        n_vec++;
        if (busy_cnt != N) begin
            n_err++;
            $display("FAIL %s_busy_len: init_busy high %0d cycles, required %0d", tag, busy_cnt, N);
        end
    endtask

    // Look up every PHT entry and compare the direction with the model.
    task automatic sweep(input string tag);
        for (int i = 0; i < N; i++) begin
            bus.lookup_valid = 1'b1;
            bus.lookup_pc    = pc_for_idx(i);
            #1;
            n_vec++;
            if (bus.pred_taken !== (m_pht[i] >= 2)) begin
                n_err++;
                $display("FAIL %s idx%0d: pred_taken=%b required %b", tag, i, bus.pred_taken, m_pht[i] >= 2);
            end
            cycle();
        end
        bus.lookup_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        watch_init("reset");
    endtask

    task automatic test_init_lookup();
        idle(1);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h0000_0040;
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1) begin
            n_err++;
            $display("FAIL init_lookup_pred: pred_taken=%b required 1", bus.pred_taken);
        end
        n_vec++;
        if (bus.pred_ghr !== 6'b000000) begin
            n_err++;
            $display("FAIL init_lookup_ghr: pred_ghr=%b required 000000", bus.pred_ghr);
        end
        cycle();
        bus.lookup_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.pred_ghr !== 6'b000001) begin
            n_err++;
            $display("FAIL init_lookup_shift: pred_ghr=%b required 000001", bus.pred_ghr);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) send_upd(32'h40, '0, 1'b0, 1'b0);
        idle(4);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc_for_idx(16);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL sat_low: pred_taken=%b required 0", bus.pred_taken);
        end
        cycle();
        bus.lookup_valid = 1'b0;
        for (int i = 0; i < 2; i++) send_upd(32'h40, '0, 1'b1, 1'b0);
        idle(3);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc_for_idx(16);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1) begin
            n_err++;
            $display("FAIL sat_recover: pred_taken=%b required 1", bus.pred_taken);
        end
        cycle();
        bus.lookup_valid = 1'b0;
    endtask

    task automatic test_queue_full();
        int accepted = 0;
        int guard    = 0;
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b1;
        bus.upd_pc = $urandom; bus.upd_ghr = GHR_W'($urandom);
        bus.upd_taken = 1'($urandom); bus.upd_mispredict = 1'b0;
        while (accepted < 6 && guard < 40) begin
            #1;
            n_vec++;
            if (bus.upd_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL qfull_ready cyc%0d: upd_ready=%b required %b", guard, bus.upd_ready, exp_ready());
            end
            if (exp_ready()) begin
                accepted++;
                cycle();
                bus.upd_pc = $urandom; bus.upd_ghr = GHR_W'($urandom);
                bus.upd_taken = 1'($urandom);
            end else begin
                cycle();
            end
            guard++;
        end
        bus.upd_valid = 1'b0;
        idle(6);
        sweep("qfull_sweep");
    endtask

    task automatic test_mispredict();
        idle(4);
        send_upd($urandom, 6'b010101, 1'b0, 1'b1);
        #1;
        n_vec++;
        if (bus.pred_ghr !== 6'b101010) begin
            n_err++;
            $display("FAIL misp_setup: pred_ghr=%b required 101010", bus.pred_ghr);
        end
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = $urandom;
        bus.upd_valid    = 1'b1;
        bus.upd_pc       = $urandom;
        bus.upd_ghr      = 6'b000111;
        bus.upd_taken    = 1'b1;
        bus.upd_mispredict = 1'b1;
        #1;
        n_vec++;
        if (bus.upd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL misp_ready: upd_ready=%b required 1", bus.upd_ready);
        end
        n_vec++;
        if (bus.pred_taken !== exp_pred(bus.lookup_pc)) begin
            n_err++;
            $display("FAIL misp_pred: pred_taken=%b required %b", bus.pred_taken, exp_pred(bus.lookup_pc));
        end
        cycle();
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.upd_mispredict = 1'b0;
        #1;
        n_vec++;
        if (bus.pred_ghr !== 6'b001111) begin
            n_err++;
            $display("FAIL misp_priority: pred_ghr=%b required 001111", bus.pred_ghr);
        end
    endtask

    task automatic test_collision();
        idle(4);
        for (int i = 0; i < 3; i++) send_upd(32'h40, '0, 1'b0, 1'b0);
        idle(5);
        send_upd(32'h40, '0, 1'b1, 1'b0);
        idle(3);
        // Counter at idx 0x10 is now weak-not-taken; the next taken update
        // drains in the cycle right after it is accepted.
        send_upd(32'h40, '0, 1'b1, 1'b0);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc_for_idx(16);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL collide_same_cycle: pred_taken=%b required 0", bus.pred_taken);
        end
        cycle();
        bus.lookup_pc = pc_for_idx(16);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b1) begin
            n_err++;
            $display("FAIL collide_next_cycle: pred_taken=%b required 1", bus.pred_taken);
        end
        cycle();
        bus.lookup_valid = 1'b0;
    endtask

    task automatic test_random();
        bit acc;
        bus.upd_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.upd_valid && ($urandom % 3 == 0)) begin
                bus.upd_valid      = 1'b1;
                bus.upd_pc         = $urandom;
                bus.upd_ghr        = GHR_W'($urandom);
                bus.upd_taken      = 1'($urandom);
                bus.upd_mispredict = ($urandom % 5 == 0);
            end
            bus.lookup_valid = 1'($urandom);
            bus.lookup_pc    = $urandom;
            #1;
            n_vec++;
            if (bus.upd_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready cyc%0d: upd_ready=%b required %b", i, bus.upd_ready, exp_ready());
            end
            n_vec++;
            if (bus.pred_ghr !== GHR_W'(m_ghr)) begin
                n_err++;
                $display("FAIL rand_ghr cyc%0d: pred_ghr=%b required %b", i, bus.pred_ghr, GHR_W'(m_ghr));
            end
            if (bus.lookup_valid) begin
                n_vec++;
                if (bus.pred_taken !== exp_pred(bus.lookup_pc)) begin
                    n_err++;
                    $display("FAIL rand_pred cyc%0d: pred_taken=%b required %b", i, bus.pred_taken, exp_pred(bus.lookup_pc));
                end
            end
            acc = bus.upd_valid && exp_ready();
            cycle();
            if (acc) bus.upd_valid = 1'b0;
        end
        idle(6);
        sweep("rand_sweep");
    endtask

    task automatic test_reset_mid();
        idle(3);
        send_upd(32'h40, '0, 1'b0, 1'b0);
        send_upd(32'h40, '0, 1'b0, 1'b0);
        // One update still queued when reset hits.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(20);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        watch_init("reset_mid");
        idle(2);
        sweep("reset_mid_sweep");
        // Weak-taken steps to weak-not-taken after one not-taken update.
        send_upd(32'h40, '0, 1'b0, 1'b0);
        idle(3);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc_for_idx(16);
        #1;
        n_vec++;
        if (bus.pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_weak: pred_taken=%b required 0", bus.pred_taken);
        end
        cycle();
        bus.lookup_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.lookup_valid = 1'b0; bus.lookup_pc = '0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_ghr = '0;
        bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b0;
        for (int i = 0; i < N; i++) m_pht[i] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_init_lookup();
        test_saturation();
        test_queue_full();
        test_mispredict();
        test_collision();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end
endmodule
